// File: rtl/dcache_pkg.sv
// Shared types, field geometry and address helpers for the direct-mapped data cache.
package dcache_pkg;

  localparam int LINE_ADDR_LEN = 3;
  localparam int SET_ADDR_LEN  = 2;
  localparam int TAG_LEN       = 30 - LINE_ADDR_LEN - SET_ADDR_LEN;
  localparam int LINE_WORDS    = 1 << LINE_ADDR_LEN;
  localparam int NUM_SETS      = 1 << SET_ADDR_LEN;
  localparam int WORD_LSB      = 2;
  localparam int SET_LSB       = WORD_LSB + LINE_ADDR_LEN;
  localparam int TAG_LSB       = SET_LSB + SET_ADDR_LEN;

  typedef logic [LINE_ADDR_LEN-1:0] word_idx_t;
  typedef logic [SET_ADDR_LEN-1:0]  set_idx_t;
  typedef logic [TAG_LEN-1:0]       tag_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WB     = 2'd1,
    S_REFILL = 2'd2
  } state_t;

  function automatic word_idx_t addr_word(input logic [31:0] addr);
    return addr[SET_LSB-1:WORD_LSB];
  endfunction

  function automatic set_idx_t addr_set(input logic [31:0] addr);
    return addr[TAG_LSB-1:SET_LSB];
  endfunction

  function automatic tag_t addr_tag(input logic [31:0] addr);
    return addr[31:TAG_LSB];
  endfunction

  function automatic logic [31:0] beat_addr(input tag_t tag, input set_idx_t set,
                                            input word_idx_t word);
    return {tag, set, word, 2'b00};
  endfunction

endpackage

// File: rtl/dcache_tag_array.sv
// Per-line valid/dirty/tag storage with combinational lookup of the addressed set.
module dcache_tag_array
  import dcache_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  set_idx_t i_set,
  input  logic     i_fill,
  input  tag_t     i_fill_tag,
  input  logic     i_mark_dirty,
  output logic     o_valid,
  output logic     o_dirty,
  output tag_t     o_tag
);

  logic [NUM_SETS-1:0] r_valid;
  logic [NUM_SETS-1:0] r_dirty;
  tag_t                r_tag [NUM_SETS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_fill) begin
      r_valid[i_set] <= 1'b1;
      r_dirty[i_set] <= 1'b0;
    end else if (i_mark_dirty) begin
      r_dirty[i_set] <= 1'b1;
    end
  end

  // NOTE: storage arrays carry no reset; the valid bit is what makes a tag meaningful.
  always_ff @(posedge clk) begin
    if (i_fill) r_tag[i_set] <= i_fill_tag;
  end

  assign o_valid = r_valid[i_set];
  assign o_dirty = r_dirty[i_set];
  assign o_tag   = r_tag[i_set];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache: combinational hits, FSM-driven
// dirty writeback and line refill over a word-wide req/ack memory port.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        miss,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  state_t    r_state, w_state_next;
  word_idx_t r_cnt, w_cnt_next;
  logic [31:0] r_data [NUM_SETS][LINE_WORDS];

  word_idx_t w_word;
  set_idx_t  w_set;
  tag_t      w_tag, w_old_tag;
  logic      w_valid, w_dirty, w_req, w_hit, w_last_beat, w_fill, w_write_hit;

  assign w_word = addr_word(addr);
  assign w_set  = addr_set(addr);
  assign w_tag  = addr_tag(addr);

  dcache_tag_array u_tags (
    .clk          (clk),
    .rst          (rst),
    .i_set        (w_set),
    .i_fill       (w_fill),
    .i_fill_tag   (w_tag),
    .i_mark_dirty (w_write_hit),
    .o_valid      (w_valid),
    .o_dirty      (w_dirty),
    .o_tag        (w_old_tag)
  );

  assign w_req       = rd_req | wr_req;
  assign w_hit       = w_req & w_valid & (w_old_tag == w_tag) & (r_state == S_IDLE);
  assign miss        = w_req & ~w_hit;
  assign rd_data     = w_hit ? r_data[w_set][w_word] : 32'h0;
  assign w_write_hit = wr_req & w_hit;
  assign w_last_beat = (r_cnt == word_idx_t'(LINE_WORDS - 1));
  assign w_fill      = (r_state == S_REFILL) & mem_ack & w_last_beat;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Refill beats and store hits never coincide: a hit requires the IDLE state.
  always_ff @(posedge clk) begin
    if (r_state == S_REFILL && mem_ack) r_data[w_set][r_cnt] <= mem_rdata;
    else if (w_write_hit)               r_data[w_set][w_word] <= wr_data;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = 32'h0;
    mem_wdata    = 32'h0;
    case (r_state)
      S_IDLE: begin
        if (miss) begin
          w_cnt_next   = '0;
          w_state_next = (w_valid & w_dirty) ? S_WB : S_REFILL;
        end
      end
      S_WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = beat_addr(w_old_tag, w_set, r_cnt);
        mem_wdata = r_data[w_set][r_cnt];
        if (mem_ack) begin
          w_cnt_next = r_cnt + 1'b1;
          if (w_last_beat) w_state_next = S_REFILL;
        end
      end
      S_REFILL: begin
        mem_req  = 1'b1;
        mem_addr = beat_addr(w_tag, w_set, r_cnt);
        if (mem_ack) begin
          w_cnt_next = r_cnt + 1'b1;
          if (w_last_beat) w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

endmodule
